// File: rtl/fft_tx_serializer.sv
// rtl/fft_tx_serializer.sv - snapshots 16 FFT result words and streams them as framed UART bytes
module fft_tx_serializer #(
    parameter int WORD_SIZE = 16,
    parameter int DATA_LENGTH = 8,
    parameter int FFT_SIZE = 16,
    parameter int HEADER_EN = 1,
    parameter logic [DATA_LENGTH-1:0] HEADER = 8'hA5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [FFT_SIZE*WORD_SIZE-1:0] i_words,
    input  logic                          i_load,
    input  logic                          i_tx_done,
    output logic                          o_tx_start,
    output logic [DATA_LENGTH-1:0]        o_tx_byte,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic                          o_overrun
);
    localparam int NDATA = 2 * FFT_SIZE;
    localparam int NBYTES = HEADER_EN + NDATA;
    localparam logic [5:0] LAST_IDX = 6'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, FINISH} state_t;

    state_t                        state;
    state_t                        next_state;
    logic [5:0]                    idx;
    logic [5:0]                    next_idx;
    logic [FFT_SIZE*WORD_SIZE-1:0] buffer;
    logic [FFT_SIZE*WORD_SIZE-1:0] byte_src;
    logic [DATA_LENGTH-1:0]        frame_bytes [NBYTES];
    logic [DATA_LENGTH-1:0]        next_byte;

    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            IDLE: begin
                if (i_load) begin
                    next_state = START;
                    next_idx   = '0;
                end
            end
            START: next_state = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (idx == LAST_IDX) begin
                        next_state = FINISH;
                    end else begin
                        next_idx   = idx + 6'd1;
                        next_state = START;
                    end
                end
            end
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Byte 0 is launched on the load edge itself, so it must come straight from i_words.
    always_comb begin
        byte_src    = (state == IDLE) ? i_words : buffer;
        frame_bytes = '{default: '0};
        for (int j = 0; j < NDATA; j++) begin
            frame_bytes[j + HEADER_EN] = byte_src[j*DATA_LENGTH +: DATA_LENGTH];
        end
        if (HEADER_EN != 0) begin
            frame_bytes[0] = HEADER;
        end
        next_byte = '0;
        for (int j = 0; j < NBYTES; j++) begin
            if (next_idx == 6'(j)) begin
                next_byte = frame_bytes[j];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_load) begin
            buffer <= i_words;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state        <= IDLE;
            idx          <= '0;
            o_tx_start   <= 1'b0;
            o_tx_byte    <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            state        <= next_state;
            idx          <= next_idx;
            o_tx_start   <= (next_state == START);
            o_busy       <= (next_state != IDLE);
            o_frame_done <= (next_state == FINISH);
            if (next_state == START) begin
                o_tx_byte <= next_byte;
            end
            if (i_load && state != IDLE) begin
                o_overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fft_tx_serializer.sv
// tb/tb_fft_tx_serializer.sv - directed and randomized frame checks for fft_tx_serializer
module tb_fft_tx_serializer;
    localparam int FFT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FFT*16-1:0] words_flat;
    logic              load_d;
    logic              done_d;
    logic              use_nh;
    logic              start1, busy1, fdone1, ovr1;
    logic [7:0]        byte1;
    logic              start0, busy0, fdone0, ovr0;
    logic [7:0]        byte0;
    logic              tx_start_o, busy_o, frame_done_o, overrun_o;
    logic [7:0]        tx_byte_o;
    logic [15:0]       w [FFT];
    logic [7:0]        q [$];
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    fft_tx_serializer dut (
        .i_clk(clk), .i_rst(rst_n), .i_words(words_flat),
        .i_load(load_d & ~use_nh), .i_tx_done(done_d & ~use_nh),
        .o_tx_start(start1), .o_tx_byte(byte1), .o_busy(busy1),
        .o_frame_done(fdone1), .o_overrun(ovr1)
    );

    fft_tx_serializer #(.HEADER_EN(0)) dut_nh (
        .i_clk(clk), .i_rst(rst_n), .i_words(words_flat),
        .i_load(load_d & use_nh), .i_tx_done(done_d & use_nh),
        .o_tx_start(start0), .o_tx_byte(byte0), .o_busy(busy0),
        .o_frame_done(fdone0), .o_overrun(ovr0)
    );

    assign tx_start_o   = use_nh ? start0 : start1;
    assign tx_byte_o    = use_nh ? byte0 : byte1;
    assign busy_o       = use_nh ? busy0 : busy1;
    assign frame_done_o = use_nh ? fdone0 : fdone1;
    assign overrun_o    = use_nh ? ovr0 : ovr1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [15:0] v);
        w[k] = v;
        words_flat[k*16 +: 16] = v;
    endtask

    task automatic random_words();
        for (int k = 0; k < FFT; k++) set_word(k, 16'($urandom));
    endtask

    task automatic ramp_words();
        for (int k = 0; k < FFT; k++) set_word(k, {8'(16 + k), 8'(k)});
    endtask

    // Expected frame: optional sync byte, then each word low byte first.
    task automatic build_q(input bit hdr);
        q.delete();
        if (hdr) q.push_back(8'hA5);
        for (int k = 0; k < FFT; k++) begin
            q.push_back(w[k][7:0]);
            q.push_back(w[k][15:8]);
        end
    endtask

    task automatic run_frame(input int gap_lo, input int gap_hi, input int ovr_at,
                             input bit fin_load, input int rst_at, input bit snap);
        int n;
        int dones;
        int wait_cnt;
        bit waiting;
        bit finished;
        n = 0; dones = 0; wait_cnt = 0; waiting = 1'b0; finished = 1'b0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(negedge clk);
            load_d = 1'b0;
            done_d = 1'b0;
            if (snap && c == 0) begin
                for (int k = 0; k < FFT; k++) set_word(k, 16'hFFFF);
            end
            if (tx_start_o) begin
                chk("start_after_done", 32'(waiting), 32'd0);
                chk("start_within_frame", 32'(n < q.size()), 32'd1);
                if (n < q.size()) chk("tx_byte", 32'(tx_byte_o), 32'(q[n]));
                chk("busy_at_start", 32'(busy_o), 32'd1);
                n++;
                waiting = 1'b1;
                wait_cnt = int'($urandom_range(gap_hi, gap_lo));
                if (n - 1 == ovr_at) begin
                    load_d = 1'b1;
                    random_words();
                end
            end else if (waiting) begin
                if (n <= q.size()) chk("tx_byte_hold", 32'(tx_byte_o), 32'(q[n-1]));
                chk("busy_in_wait", 32'(busy_o), 32'd1);
                chk("no_early_frame_done", 32'(frame_done_o), 32'd0);
                wait_cnt--;
                if (n - 1 == rst_at && wait_cnt == 1) begin
                    rst_n = 1'b0;
                    finished = 1'b1;
                end else if (wait_cnt == 0) begin
                    done_d = 1'b1;
                    waiting = 1'b0;
                    dones++;
                end
            end else if (frame_done_o) begin
                chk("bytes_per_frame", 32'(n), 32'(q.size()));
                chk("dones_per_frame", 32'(dones), 32'(q.size()));
                chk("busy_at_frame_done", 32'(busy_o), 32'd1);
                if (fin_load) load_d = 1'b1;
                finished = 1'b1;
            end else begin
                chk("frame_progress", 32'(tx_start_o), 32'd1);
            end
        end
        if (!finished) chk("frame_timeout", 32'(finished), 32'd1);
    endtask

    task automatic post(input bit exp_ovr);
        @(negedge clk);
        load_d = 1'b0;
        done_d = 1'b0;
        chk("busy_after_frame", 32'(busy_o), 32'd0);
        chk("frame_done_single", 32'(frame_done_o), 32'd0);
        chk("no_start_after_frame", 32'(tx_start_o), 32'd0);
        chk("overrun_flag", 32'(overrun_o), 32'(exp_ovr));
    endtask

    task automatic idle_cycles(input int n, input bit rand_done);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load_d = 1'b0;
            done_d = rand_done ? 1'($urandom) : 1'b0;
            chk("idle_no_start", 32'(tx_start_o), 32'd0);
            chk("idle_not_busy", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_d = 1'b0; done_d = 1'b0; use_nh = 1'b0;
        words_flat = '0;
        for (int k = 0; k < FFT; k++) w[k] = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_d = 1'($urandom);
            done_d = 1'($urandom);
            chk("reset_outputs", 32'({start1, byte1, busy1, fdone1, ovr1}), 32'd0);
            chk("reset_outputs_nh", 32'({start0, byte0, busy0, fdone0, ovr0}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1; load_d = 1'b0; done_d = 1'b0;
        chk("reset_outputs_last", 32'({start1, byte1, busy1, fdone1, ovr1}), 32'd0);
        idle_cycles(5, 1'b1);

        ramp_words();
        build_q(1'b1);
        load_d = 1'b1;
        run_frame(20, 20, -1, 1'b0, -1, 1'b0);
        post(1'b0);

        random_words();
        build_q(1'b1);
        load_d = 1'b1;
        run_frame(1, 6, -1, 1'b0, -1, 1'b1);
        post(1'b0);
        build_q(1'b1);
        load_d = 1'b1;
        run_frame(1, 4, -1, 1'b0, -1, 1'b0);
        post(1'b0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            done_d = 1'b1;
            @(negedge clk);
            done_d = 1'b0;
            chk("idle_done_ignored", 32'({tx_start_o, busy_o}), 32'd0);
        end
        random_words();
        build_q(1'b1);
        load_d = 1'b1;
        run_frame(2, 8, 5, 1'b1, -1, 1'b0);
        post(1'b1);
        idle_cycles(6, 1'b0);
        chk("overrun_sticky", 32'(overrun_o), 32'd1);

        for (int f = 0; f < 3; f++) begin
            random_words();
            build_q(1'b1);
            load_d = 1'b1;
            run_frame(1, 10, -1, 1'b0, -1, 1'b0);
            post(1'b1);
        end

        random_words();
        build_q(1'b1);
        load_d = 1'b1;
        run_frame(2, 6, -1, 1'b0, 10, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midframe_reset_outputs", 32'({tx_start_o, tx_byte_o, busy_o, frame_done_o, overrun_o}), 32'd0);
        idle_cycles(20, 1'b1);
        random_words();
        build_q(1'b1);
        load_d = 1'b1;
        run_frame(1, 5, -1, 1'b0, -1, 1'b0);
        post(1'b0);

        @(negedge clk);
        use_nh = 1'b1;
        ramp_words();
        build_q(1'b0);
        load_d = 1'b1;
        run_frame(3, 3, -1, 1'b0, -1, 1'b0);
        post(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
